mem_stage: RTL and testbench

//  MEM pipeline stage between EX and WB of the 5-stage MIPS core. Registers the EX->MEM bus under stall control,

---
 rtl/mem_stage.sv | 72 +++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage, registers EX->MEM, extracts load data, drives MEM->WB and MEM->ID buses.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned lw/lh/lhu on mem_adel and suppresses their GPR write.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 146,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_ID_WD = 104,
  parameter int STALL_WD = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_adel
);
  logic [EX_TO_MEM_WD-1:0] r;
  logic first_r, hold_v;
  logic [31:0] hold_r;
  logic [3:0] readen, ram_wen;
  logic hi_we, lo_we, ram_en, sel_rf_res, rf_we, we;
  logic [31:0] hi, lo, pc, addr, ld_word, ext, rf_wdata;
  logic [4:0] rf_waddr;
  logic [7:0] b;
  logic [15:0] h;
  logic is_load, unused;
  assign {readen, hi_we, lo_we, hi, lo, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, addr} = r;
  assign unused = ^{ram_wen, stall[5], stall[2:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      first_r <= 1'b0;
      hold_v <= 1'b0;
      hold_r <= '0;
    end else if (!stall[3]) begin
      r <= ex_to_mem_bus;
      first_r <= 1'b1;
      hold_v <= 1'b0;
    end else if (!stall[4]) begin
      r <= '0;
      first_r <= 1'b0;
      hold_v <= 1'b0;
    end else begin
      first_r <= 1'b0;
      // SRAM rdata lasts one cycle; capture it if WB stalls on the first MEM cycle
      if (first_r && ram_en) begin
        hold_r <= data_sram_rdata;
        hold_v <= 1'b1;
      end
    end
  always_comb begin
    ld_word = hold_v ? hold_r : data_sram_rdata;
    b = ld_word[{addr[1:0], 3'b000} +: 8];
    h = addr[1] ? ld_word[31:16] : ld_word[15:0];
    is_load = readen inside {4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
    ext = readen == 4'b1111 ? ld_word :
          readen == 4'b0001 ? {{24{b[7]}}, b} :
          readen == 4'b0010 ? {24'b0, b} :
          readen == 4'b0011 ? {{16{h[15]}}, h} : {16'b0, h};
    rf_wdata = (sel_rf_res && is_load) ? ext : addr;
`ifdef MEM_ALIGN_CHECK_EN
    mem_adel = (readen == 4'b1111 && addr[1:0] != 2'b00) ||
               ((readen == 4'b0011 || readen == 4'b0100) && addr[0]);
`else
    mem_adel = 1'b0;
`endif
    we = rf_we & ~mem_adel;
  end
  assign mem_to_wb_bus = {hi_we, lo_we, hi, lo, pc, we, rf_waddr, rf_wdata};
  assign mem_to_id_bus = {we, rf_waddr, rf_wdata, hi_we, lo_we, hi, lo};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, stall/reset sequences and random loads checked against a field-level model.
module tb_mem_stage;
  logic clk = 1'b0, rst;
  logic [5:0] stall;
  logic [145:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_id_bus;
  logic mem_adel;
  int n_pass = 0, n_total = 0;

  mem_stage dut (.clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata), .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_id_bus(mem_to_id_bus), .mem_adel(mem_adel));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] readen;
    logic hi_we, lo_we;
    logic [31:0] hi, lo, pc;
    logic ram_en;
    logic [3:0] wen;
    logic sel, rf_we;
    logic [4:0] waddr;
    logic [31:0] res;
  } ins_t;

  typedef struct {
    logic [3:0] readen;
    logic [31:0] addr, w, exp;
  } vec_t;

  function automatic logic [145:0] pack(ins_t i);
    return {i.readen, i.hi_we, i.lo_we, i.hi, i.lo, i.pc, i.ram_en, i.wen, i.sel, i.rf_we, i.waddr, i.res};
  endfunction

  function automatic ins_t ld(logic [3:0] readen, logic [31:0] addr, logic [4:0] waddr);
    ins_t i;
    i = '{readen: readen, hi_we: 1'b0, lo_we: 1'b0, hi: 32'h0, lo: 32'h0, pc: 32'hBFC0_0000 + addr,
          ram_en: 1'b1, wen: 4'b0, sel: 1'b1, rf_we: 1'b1, waddr: waddr, res: addr};
    return i;
  endfunction

  // Expected {wb, id, adel} from the instruction fields and the loaded SRAM word
  function automatic logic [240:0] model(ins_t i, logic [31:0] w);
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] d;
    logic adel, we;
    b = 8'(w >> (8 * i.res[1:0]));
    h = i.res[1] ? w[31:16] : w[15:0];
    case (i.readen)
      4'hF: d = w;
      4'h1: d = 32'($signed(b));
      4'h2: d = {24'b0, b};
      4'h3: d = 32'($signed(h));
      4'h4: d = {16'b0, h};
      default: d = i.res;
    endcase
    if (!i.sel) d = i.res;
    adel = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    adel = (i.readen == 4'hF && i.res[1:0] != 2'b00) || ((i.readen == 4'h3 || i.readen == 4'h4) && i.res[0]);
`endif
    we = i.rf_we & ~adel;
    return {i.hi_we, i.lo_we, i.hi, i.lo, i.pc, we, i.waddr, d,
            we, i.waddr, d, i.hi_we, i.lo_we, i.hi, i.lo, adel};
  endfunction

  task automatic chk(string name, logic [240:0] exp);
    logic [240:0] act;
    act = {mem_to_wb_bus, mem_to_id_bus, mem_adel};
    n_total++;
    if (act !== exp) $display("FAIL %s got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_wd(string name, logic [31:0] exp);
    n_total++;
    if (mem_to_wb_bus[31:0] !== exp) $display("FAIL %s rf_wdata got %h expected %h", name, mem_to_wb_bus[31:0], exp);
    else n_pass++;
  endtask

  task automatic issue(ins_t i, logic [31:0] w);
    ex_to_mem_bus = pack(i);
    stall = 6'b0;
    @(posedge clk);
    #1 data_sram_rdata = w;
    #1;
  endtask

  function automatic ins_t rnd_ins();
    logic [3:0] codes [9];
    ins_t i;
    codes = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h0, 4'h6};
    i = '{readen: codes[$urandom_range(0, 8)], hi_we: 1'($urandom), lo_we: 1'($urandom), hi: $urandom,
          lo: $urandom, pc: $urandom, ram_en: 1'($urandom), wen: 4'($urandom), sel: ($urandom_range(0, 3) != 0),
          rf_we: 1'($urandom), waddr: 5'($urandom), res: $urandom};
    return i;
  endfunction

  initial begin
    #200000 $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl [12];
    ins_t i, m;
    logic [240:0] e;
    tbl[0]  = '{4'hF, 32'h100, 32'h8899AABB, 32'h8899AABB};
    tbl[1]  = '{4'h1, 32'h103, 32'h80112233, 32'hFFFFFF80};
    tbl[2]  = '{4'h2, 32'h103, 32'h80112233, 32'h00000080};
    tbl[3]  = '{4'h4, 32'h102, 32'h80112233, 32'h00008011};
    tbl[4]  = '{4'h3, 32'h100, 32'h1234F00D, 32'hFFFFF00D};
    tbl[5]  = '{4'h1, 32'h101, 32'h80112233, 32'h00000022};
    tbl[6]  = '{4'h3, 32'h102, 32'h80112233, 32'hFFFF8011};
    tbl[7]  = '{4'h2, 32'h100, 32'h000000FE, 32'h000000FE};
    tbl[8]  = '{4'h5, 32'h100, 32'h80112233, 32'h00000100};
    tbl[9]  = '{4'h7, 32'h102, 32'h80112233, 32'h00000102};
    tbl[10] = '{4'h0, 32'h104, 32'h80112233, 32'h00000104};
    tbl[11] = '{4'hF, 32'h102, 32'h80112233, 32'h80112233};
    rst = 1'b1;
    stall = 6'b0;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    #12 chk("reset", '0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      i = ld(tbl[k].readen, tbl[k].addr, 5'(k + 7));
      issue(i, tbl[k].w);
      chk($sformatf("tbl%0d_model", k), model(i, tbl[k].w));
      chk_wd($sformatf("tbl%0d_wdata", k), tbl[k].exp);
    end
    i = ld(4'h3, 32'h100, 5'd9);
    issue(i, 32'h1234F00D);
    e = model(i, 32'h1234F00D);
    chk("hold_first", e);
    stall = 6'b011111;
    ex_to_mem_bus = pack(rnd_ins());
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 data_sram_rdata = 32'hDEADBEEF;
      #1 chk($sformatf("hold_cyc%0d", k), e);
      chk_wd($sformatf("hold_wd%0d", k), 32'hFFFFF00D);
    end
    stall = 6'b0;
    #1 chk("hold_release", e);
    m = ld(4'h0, 32'hCAFE, 5'd0);
    m.hi_we = 1'b1;
    m.lo_we = 1'b1;
    m.hi = 32'h1;
    m.lo = 32'hFFFFFFFE;
    m.ram_en = 1'b0;
    m.sel = 1'b0;
    m.rf_we = 1'b0;
    issue(m, 32'h55AA55AA);
    e = model(m, 32'h55AA55AA);
    chk("mult", e);
    chk_wd("mult_wdata", 32'hCAFE);
    stall = 6'b011111;
    ex_to_mem_bus = pack(rnd_ins());
    @(posedge clk);
    #1 data_sram_rdata = 32'h0BADF00D;
    #1 chk("full_stall", e);
    stall = 6'b001000;
    @(posedge clk);
    #2 chk("bubble", '0);
    i = ld(4'hF, 32'h200, 5'd3);
    issue(i, 32'hA5A50001);
    stall = 6'b011111;
    @(posedge clk);
    #1 data_sram_rdata = 32'hDEADBEEF;
    #1 rst = 1'b1;
    #1 chk("rst_async", '0);
    #2 rst = 1'b0;
    i = ld(4'hF, 32'h100, 5'd4);
    issue(i, 32'h11223344);
    chk("post_rst_live", model(i, 32'h11223344));
    chk_wd("post_rst_wdata", 32'h11223344);
    for (int k = 0; k < 150; k++) begin
      logic [31:0] w;
      i = rnd_ins();
      w = $urandom;
      issue(i, w);
      chk($sformatf("rand%0d", k), model(i, w));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
